pipe_mux_n: RTL

Parametrised N-way, WIDTH-bit selector with a registered, flow-controlled output. It is the next generation of the ALU's 2:1 select: it generalises to N inputs of arbitrary width, adds a valid/ready handshake with a two-entry skid buffer, a synchronous flush and out-of-range select detection. It sits between ALU/forwarding result sources and the next pipeline stage, so that a downstream stall never drops or duplicates a result.

---
 rtl/pipe_mux_pkg.sv | 23 ++
 rtl/pipe_mux_n_mux.sv | 36 +++
 rtl/pipe_mux_n.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipe_mux_pkg.sv
// pipe_mux_pkg
// Shared definitions for the flow-controlled N-way selector.
//   muxState_t    : occupancy of the output stage (EMPTY, ONE, FULL)
//   MAX_WIDTH     : widest data word the DEFAULT helper can produce
//   extendDefault : zero-extends the 64-bit DEFAULT parameter so that
//                   any channel width up to MAX_WIDTH can take a slice
package pipe_mux_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } muxState_t;

    localparam int MAX_WIDTH = 1024;

    // DEFAULT is carried as a 64-bit parameter. Narrower channels take
    // the low bits. Wider channels see zeros above bit 63.
    function automatic logic [MAX_WIDTH-1:0] extendDefault(input logic [63:0] value);
        return {{(MAX_WIDTH - 64){1'b0}}, value};
    endfunction

endpackage

// File: rtl/pipe_mux_n_mux.sv
// mux_n_to_1
// Combinational N-way selector over packed WIDTH-bit channels.
//   channels   in  N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   sel        in  SELW     channel index
//   word       out WIDTH    selected channel, or DEFAULT when sel >= N
//   outOfRange out 1        high when sel does not name a channel
module mux_n_to_1 #(
    parameter int          WIDTH   = 32,
    parameter int          N       = 4,
    parameter logic [63:0] DEFAULT = 64'd0
) (
    input  logic [N*WIDTH-1:0]     channels,
    input  logic [$clog2(N)-1:0]   sel,
    output logic [WIDTH-1:0]       word,
    output logic                   outOfRange
);
    import pipe_mux_pkg::*;

    localparam logic [MAX_WIDTH-1:0] DEFAULT_EXT  = extendDefault(DEFAULT);
    localparam logic [WIDTH-1:0]     DEFAULT_WORD = DEFAULT_EXT[WIDTH-1:0];

    // Start from the out-of-range answer and let a matching channel
    // override it. When N is not a power of two, some sel codes match
    // no channel and keep the DEFAULT word.
    always_comb begin
        word       = DEFAULT_WORD;
        outOfRange = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (int'(sel) == i) begin
                word       = channels[i*WIDTH +: WIDTH];
                outOfRange = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipe_mux_n.sv
// pipe_mux_n
// N-way WIDTH-bit selector with a registered valid/ready output stage.
// It holds up to two words: the main register and one skid register.
// The skid register catches the word accepted in the same cycle that
// downstream stalls, so that the ready output can stay registered.
//   Clk, Reset      clock, synchronous active-high reset
//   In, Sel         packed channels and the select sampled on accept
//   InValid/InReady upstream handshake (InReady low only when FULL)
//   Flush           synchronous discard of both held words
//   Out, SelErr     held word and its out-of-range flag
//   OutValid/OutReady downstream handshake
module pipe_mux_n #(
    parameter int          WIDTH   = 32,
    parameter int          N       = 4,
    parameter logic [63:0] DEFAULT = 64'd0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [N*WIDTH-1:0]     In,
    input  logic [$clog2(N)-1:0]   Sel,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic                   Flush,
    output logic [WIDTH-1:0]       Out,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic                   SelErr
);
    import pipe_mux_pkg::*;

    muxState_t        state;
    muxState_t        nextState;
    logic [WIDTH-1:0] capWord;
    logic             capErr;
    logic [WIDTH-1:0] skidWord;
    logic             skidErr;
    logic             accept;
    logic             loadMainFromIn;
    logic             loadMainFromSkid;
    logic             loadSkid;

    mux_n_to_1 #(
        .WIDTH   (WIDTH),
        .N       (N),
        .DEFAULT (DEFAULT)
    ) u_mux (
        .channels   (In),
        .sel        (Sel),
        .word       (capWord),
        .outOfRange (capErr)
    );

    // Both handshake outputs decode the state register alone. This
    // keeps OutReady from reaching InReady through combinational logic.
    assign InReady  = (state != FULL);
    assign OutValid = (state != EMPTY);
    assign accept   = InValid && InReady;

    // Next-state and register-load decisions. In ONE with a stalled
    // output, a new word goes to the skid register. When the output
    // drains from FULL, the skid word moves up into the main register.
    // Flush overrides everything and drops any word offered that cycle.
    always_comb begin
        nextState        = state;
        loadMainFromIn   = 1'b0;
        loadMainFromSkid = 1'b0;
        loadSkid         = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    nextState      = ONE;
                    loadMainFromIn = 1'b1;
                end
            end
            ONE: begin
                if (accept && OutReady) begin
                    loadMainFromIn = 1'b1;
                end else if (accept) begin
                    nextState = FULL;
                    loadSkid  = 1'b1;
                end else if (OutReady) begin
                    nextState = EMPTY;
                end
            end
            FULL: begin
                if (OutReady) begin
                    nextState        = ONE;
                    loadMainFromSkid = 1'b1;
                end
            end
            default: begin
                nextState = EMPTY;
            end
        endcase
        if (Flush) begin
            nextState        = EMPTY;
            loadMainFromIn   = 1'b0;
            loadMainFromSkid = 1'b0;
            loadSkid         = 1'b0;
        end
    end

    // State and data registers. Reset clears both words. Flush only
    // empties the state. The stale data left behind is never presented
    // as valid.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= EMPTY;
            Out      <= '0;
            SelErr   <= 1'b0;
            skidWord <= '0;
            skidErr  <= 1'b0;
        end else begin
            state <= nextState;
            if (loadMainFromIn) begin
                Out    <= capWord;
                SelErr <= capErr;
            end else if (loadMainFromSkid) begin
                Out    <= skidWord;
                SelErr <= skidErr;
            end
            if (loadSkid) begin
                skidWord <= capWord;
                skidErr  <= capErr;
            end
        end
    end

endmodule
